// File: rtl/axis_crc32_mpeg2_append_pkg.sv
// Shared constants, state type and the bit-serial CRC-32/MPEG-2 step for the AXI-Stream appender.
package pkg_axis_crc;

  localparam logic [31:0] DEFAULT_POLY_CRC = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_INIT_CRC = 32'hFFFFFFFF;
  localparam int unsigned MAX_DATA_WIDTH   = 64;

  typedef enum logic {PASS, APPEND} crc_app_state_t;

  // Only the low 'width' bits of word are used, consumed MSB-first.
  function automatic logic [31:0] crc32_mpeg2_step(input logic [31:0]               crc,
                                                   input logic [MAX_DATA_WIDTH-1:0] word,
                                                   input logic [31:0]               poly,
                                                   input int unsigned               width);
    logic [31:0] c;
    logic        fb;
    c  = crc;
    fb = 1'b0;
    for (int i = MAX_DATA_WIDTH - 1; i >= 0; i--) begin
      if (i < int'(width)) begin
        fb = c[31] ^ word[i];
        c  = {c[30:0], 1'b0} ^ (fb ? poly : 32'h0);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_crc32_out_reg.sv
// One-deep AXI-Stream output register; full throughput because it reloads on the draining edge.
module axis_crc32_out_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  out_free
);

  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;

  assign out_free      = ~tvalid_q | m_axis_tready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

  // load is only ever asserted while out_free, so a pending beat is never overwritten.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (load) begin
      tdata_q  <= load_data;
      tvalid_q <= 1'b1;
      tlast_q  <= load_last;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_crc32_mpeg2_append.sv
// Forwards AXI-Stream frames unchanged and appends one beat carrying the frame's CRC-32/MPEG-2.
module axis_crc32_mpeg2_append
  import pkg_axis_crc::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [31:0] POLY_CRC       = DEFAULT_POLY_CRC,
  parameter logic [31:0] INIT_CRC       = DEFAULT_INIT_CRC
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      crc_done,
  output logic [31:0]               crc_value
);

  crc_app_state_t            state_q, state_d;
  logic [31:0]               crc_q, crc_d;
  logic [31:0]               crc_value_q, crc_value_d;
  logic                      crc_done_q, crc_done_d;
  logic                      out_free;
  logic                      load;
  logic [AXI_DATA_WIDTH-1:0] load_data;
  logic                      load_last;

  always_comb begin
    state_d       = state_q;
    crc_d         = crc_q;
    crc_value_d   = crc_value_q;
    crc_done_d    = 1'b0;
    s_axis_tready = 1'b0;
    load          = 1'b0;
    load_data     = s_axis_tdata;
    load_last     = 1'b0;
    unique case (state_q)
      PASS: begin
        s_axis_tready = out_free & aresetn;
        if (s_axis_tvalid && s_axis_tready) begin
          load  = 1'b1;
          crc_d = crc32_mpeg2_step(crc_q, MAX_DATA_WIDTH'(s_axis_tdata), POLY_CRC,
                                   AXI_DATA_WIDTH);
          if (s_axis_tlast) state_d = APPEND;
        end
      end
      APPEND: begin
        if (out_free) begin
          load        = 1'b1;
          load_data   = AXI_DATA_WIDTH'(crc_q);
          load_last   = 1'b1;
          crc_value_d = crc_q;
          crc_done_d  = 1'b1;
          crc_d       = INIT_CRC;
          state_d     = PASS;
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= PASS;
      crc_q       <= INIT_CRC;
      crc_value_q <= INIT_CRC;
      crc_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_value_q <= crc_value_d;
      crc_done_q  <= crc_done_d;
    end
  end

  assign crc_done  = crc_done_q;
  assign crc_value = crc_value_q;

  axis_crc32_out_reg #(
    .DATA_WIDTH (AXI_DATA_WIDTH)
  ) u_out_reg (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .load          (load),
    .load_data     (load_data),
    .load_last     (load_last),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .out_free      (out_free)
  );

endmodule
